// File: rtl/autoconfig_host.sv
// Zorro II AutoConfig initiator: runs 68000-style cycles at $E8xxxx, reads each board's identity
// nibbles, then assigns an aligned base in the Zorro II window or shuts the board up.
module autoconfig_host #(
  parameter int         DTACK_TIMEOUT = 64,
  parameter int         MAX_BOARDS    = 7,
  parameter logic [7:0] WINDOW_HI     = 8'hA0
) (
  input  logic        MB_CLK,
  input  logic        RESET,
  input  logic        START,
  input  logic [7:0]  ALLOC_BASE,
  output logic        BUS_AS,
  output logic        BUS_UDS,
  output logic        BUS_LDS,
  output logic        BUS_RW,
  output logic [22:0] BUS_ADDR,
  output logic [3:0]  DATA_OUT,
  output logic        DATA_OE,
  input  logic [3:0]  DATA_IN,
  input  logic        BUS_DTACK,
  output logic        BUSY,
  output logic        DONE,
  output logic [2:0]  BOARD_COUNT,
  output logic        ERR,
  output logic [7:0]  LAST_TYPE,
  output logic [7:0]  LAST_PRODUCT,
  output logic [15:0] LAST_MFG
);

  localparam int CW = $clog2(DTACK_TIMEOUT) + 1;

  typedef enum logic [2:0] {
    B_IDLE, B_ADDR, B_ASSERT, B_WAIT, B_LATCH, B_END, B_REL
  } bus_state_t;

  typedef enum logic [3:0] {
    S_IDLE, S_PROBE, S_READ_ID, S_DECIDE, S_ASSIGN_LO, S_ASSIGN_HI, S_SHUTUP, S_NEXT, S_FINISH
  } state_t;

  // Bus cycle engine state
  bus_state_t    bst_q, bst_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          to_q, to_d;
  logic [22:0]   addr_q, addr_d;
  logic          rw_q, rw_d;
  logic [3:0]    wdata_q, wdata_d;
  logic [3:0]    rdata_q, rdata_d;

  // Enumeration state
  state_t      st_q, st_d;
  logic [2:0]  rd_idx_q, rd_idx_d;
  logic [7:0]  type_q, type_d;
  logic [7:0]  prod_q, prod_d;
  logic [15:0] mfg_q, mfg_d;
  logic [7:0]  base_q, base_d;
  logic [7:0]  next_base_q, next_base_d;
  logic [2:0]  count_q, count_d;
  logic [2:0]  shut_q, shut_d;
  logic        err_q, err_d;

  // Request from the enumeration FSM to the engine
  logic        bus_req;
  logic [6:0]  req_idx;
  logic        req_rw;
  logic [3:0]  req_wdata;
  logic        bus_done;
  logic [6:0]  rd_word;

  logic [8:0]  units;
  logic [8:0]  aligned;
  logic [9:0]  alloc_end;
  logic        fits;
  logic        as_active;

  // ---------------------------------------------------------------- bus engine
  always_ff @(posedge MB_CLK or negedge RESET) begin
    if (!RESET) begin
      bst_q   <= B_IDLE;
      cnt_q   <= '0;
      to_q    <= 1'b0;
      addr_q  <= '0;
      rw_q    <= 1'b1;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      bst_q   <= bst_d;
      cnt_q   <= cnt_d;
      to_q    <= to_d;
      addr_q  <= addr_d;
      rw_q    <= rw_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  always_comb begin
    bst_d   = bst_q;
    cnt_d   = cnt_q;
    to_d    = to_q;
    addr_d  = addr_q;
    rw_d    = rw_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    unique case (bst_q)
      B_IDLE: begin
        if (bus_req) begin
          bst_d   = B_ADDR;
          addr_d  = {8'hE8, 8'h00, req_idx};
          rw_d    = req_rw;
          wdata_d = req_wdata;
          to_d    = 1'b0;
        end
      end
      B_ADDR: bst_d = B_ASSERT;
      B_ASSERT: begin
        // cnt tracks cycles with /AS low, so the ASSERT cycle counts as the first
        bst_d = B_WAIT;
        cnt_d = CW'(1);
      end
      B_WAIT: begin
        if (!BUS_DTACK) begin
          bst_d = B_LATCH;
        end else if (cnt_q == CW'(DTACK_TIMEOUT - 1)) begin
          to_d  = 1'b1;
          bst_d = B_END;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      B_LATCH: begin
        if (rw_q) rdata_d = DATA_IN;
        bst_d = B_END;
      end
      B_END: bst_d = B_REL;
      B_REL: begin
        bst_d = B_IDLE;
        rw_d  = 1'b1;
      end
      default: bst_d = B_IDLE;
    endcase
  end

  assign as_active = (bst_q == B_ASSERT) || (bst_q == B_WAIT) || (bst_q == B_LATCH);
  assign bus_done  = (bst_q == B_REL);

  assign BUS_AS   = ~as_active;
  assign BUS_UDS  = ~as_active;
  assign BUS_LDS  = 1'b1;
  assign BUS_RW   = rw_q;
  assign BUS_ADDR = addr_q;
  assign DATA_OUT = wdata_q;
  // Data stays driven through END; released during the REL idle cycle
  assign DATA_OE  = ~rw_q && (bst_q != B_IDLE) && (bst_q != B_REL);

  // ---------------------------------------------------------------- allocation math
  always_comb begin
    unique case (type_q[2:0])
      3'b000:  units = 9'd128;
      3'b001:  units = 9'd1;
      3'b010:  units = 9'd2;
      3'b011:  units = 9'd4;
      3'b100:  units = 9'd8;
      3'b101:  units = 9'd16;
      3'b110:  units = 9'd32;
      default: units = 9'd64;
    endcase
  end

  assign aligned   = ({1'b0, next_base_q} + units - 9'd1) & ~(units - 9'd1);
  assign alloc_end = {1'b0, aligned} + {1'b0, units};
  assign fits      = (type_q[7:6] == 2'b11) && (alloc_end <= {2'b00, WINDOW_HI});

  always_comb begin
    unique case (rd_idx_q)
      3'd0:    rd_word = 7'h01;
      3'd1:    rd_word = 7'h02;
      3'd2:    rd_word = 7'h03;
      3'd3:    rd_word = 7'h08;
      3'd4:    rd_word = 7'h09;
      3'd5:    rd_word = 7'h0A;
      default: rd_word = 7'h0B;
    endcase
  end

  // ---------------------------------------------------------------- enumeration FSM
  always_ff @(posedge MB_CLK or negedge RESET) begin
    if (!RESET) begin
      st_q        <= S_IDLE;
      rd_idx_q    <= '0;
      type_q      <= '0;
      prod_q      <= '0;
      mfg_q       <= '0;
      base_q      <= '0;
      next_base_q <= '0;
      count_q     <= '0;
      shut_q      <= '0;
      err_q       <= 1'b0;
    end else begin
      st_q        <= st_d;
      rd_idx_q    <= rd_idx_d;
      type_q      <= type_d;
      prod_q      <= prod_d;
      mfg_q       <= mfg_d;
      base_q      <= base_d;
      next_base_q <= next_base_d;
      count_q     <= count_d;
      shut_q      <= shut_d;
      err_q       <= err_d;
    end
  end

  always_comb begin
    st_d        = st_q;
    rd_idx_d    = rd_idx_q;
    type_d      = type_q;
    prod_d      = prod_q;
    mfg_d       = mfg_q;
    base_d      = base_q;
    next_base_d = next_base_q;
    count_d     = count_q;
    shut_d      = shut_q;
    err_d       = err_q;
    bus_req     = 1'b0;
    req_idx     = 7'h00;
    req_rw      = 1'b1;
    req_wdata   = 4'h0;
    unique case (st_q)
      S_IDLE: begin
        if (START) begin
          st_d        = S_PROBE;
          count_d     = '0;
          shut_d      = '0;
          err_d       = 1'b0;
          type_d      = '0;
          prod_d      = '0;
          mfg_d       = '0;
          next_base_d = ALLOC_BASE;
        end
      end
      S_PROBE: begin
        bus_req = 1'b1;
        if (bus_done) begin
          if (to_q) begin
            st_d = S_FINISH;
          end else begin
            type_d   = {rdata_q, type_q[3:0]};
            rd_idx_d = '0;
            st_d     = S_READ_ID;
          end
        end
      end
      S_READ_ID: begin
        bus_req = 1'b1;
        req_idx = rd_word;
        if (bus_done) begin
          if (to_q) begin
            err_d = 1'b1;
            st_d  = S_FINISH;
          end else begin
            // Product and manufacturer nibbles are stored inverted on the card
            unique case (rd_idx_q)
              3'd0:    type_d = {type_q[7:4], rdata_q};
              3'd1:    prod_d = {~rdata_q, prod_q[3:0]};
              3'd2:    prod_d = {prod_q[7:4], ~rdata_q};
              3'd3:    mfg_d  = {~rdata_q, mfg_q[11:0]};
              3'd4:    mfg_d  = {mfg_q[15:12], ~rdata_q, mfg_q[7:0]};
              3'd5:    mfg_d  = {mfg_q[15:8], ~rdata_q, mfg_q[3:0]};
              default: mfg_d  = {mfg_q[15:4], ~rdata_q};
            endcase
            if (rd_idx_q == 3'd6) st_d = S_DECIDE;
            else                  rd_idx_d = rd_idx_q + 3'd1;
          end
        end
      end
      S_DECIDE: begin
        if (fits) begin
          base_d = aligned[7:0];
          st_d   = S_ASSIGN_LO;
        end else begin
          err_d = 1'b1;
          st_d  = S_SHUTUP;
        end
      end
      S_ASSIGN_LO: begin
        bus_req   = 1'b1;
        req_idx   = 7'h25;
        req_rw    = 1'b0;
        req_wdata = base_q[3:0];
        if (bus_done) begin
          if (to_q) begin
            err_d = 1'b1;
            st_d  = S_FINISH;
          end else begin
            st_d = S_ASSIGN_HI;
          end
        end
      end
      S_ASSIGN_HI: begin
        bus_req   = 1'b1;
        req_idx   = 7'h24;
        req_rw    = 1'b0;
        req_wdata = base_q[7:4];
        if (bus_done) begin
          if (to_q) begin
            err_d = 1'b1;
            st_d  = S_FINISH;
          end else begin
            next_base_d = alloc_end[7:0];
            count_d     = count_q + 3'd1;
            st_d        = S_NEXT;
          end
        end
      end
      S_SHUTUP: begin
        bus_req = 1'b1;
        req_idx = 7'h26;
        req_rw  = 1'b0;
        if (bus_done) begin
          if (to_q) begin
            st_d = S_FINISH;
          end else begin
            shut_d = shut_q + 3'd1;
            st_d   = S_NEXT;
          end
        end
      end
      S_NEXT: begin
        if (({1'b0, count_q} + {1'b0, shut_q}) == 4'(MAX_BOARDS)) st_d = S_FINISH;
        else                                                       st_d = S_PROBE;
      end
      S_FINISH: st_d = S_IDLE;
      default:  st_d = S_IDLE;
    endcase
  end

  assign BUSY         = (st_q != S_IDLE) && (st_q != S_FINISH);
  assign DONE         = (st_q == S_FINISH);
  assign BOARD_COUNT  = count_q;
  assign ERR          = err_q;
  assign LAST_TYPE    = type_q;
  assign LAST_PRODUCT = prod_q;
  assign LAST_MFG     = mfg_q;

endmodule

// File: tb/tb_autoconfig_host.sv
// Scoreboard bench for autoconfig_host: a responder models the AutoConfig chain, stimulus queues
// expected bus writes and DONE results, and a monitor pops and compares them as the DUT produces them.
`timescale 1ns/1ps
module tb_autoconfig_host;

  logic        MB_CLK = 1'b0;
  logic        RESET = 1'b0;
  logic        START = 1'b0;
  logic [7:0]  ALLOC_BASE = 8'h00;
  logic        BUS_AS, BUS_UDS, BUS_LDS, BUS_RW;
  logic [22:0] BUS_ADDR;
  logic [3:0]  DATA_OUT;
  logic        DATA_OE;
  logic [3:0]  DATA_IN = 4'h0;
  logic        BUS_DTACK = 1'b1;
  logic        BUSY, DONE, ERR;
  logic [2:0]  BOARD_COUNT;
  logic [7:0]  LAST_TYPE, LAST_PRODUCT;
  logic [15:0] LAST_MFG;

  autoconfig_host dut (
    .MB_CLK(MB_CLK), .RESET(RESET), .START(START), .ALLOC_BASE(ALLOC_BASE),
    .BUS_AS(BUS_AS), .BUS_UDS(BUS_UDS), .BUS_LDS(BUS_LDS), .BUS_RW(BUS_RW),
    .BUS_ADDR(BUS_ADDR), .DATA_OUT(DATA_OUT), .DATA_OE(DATA_OE), .DATA_IN(DATA_IN),
    .BUS_DTACK(BUS_DTACK), .BUSY(BUSY), .DONE(DONE), .BOARD_COUNT(BOARD_COUNT),
    .ERR(ERR), .LAST_TYPE(LAST_TYPE), .LAST_PRODUCT(LAST_PRODUCT), .LAST_MFG(LAST_MFG)
  );

  always #5 MB_CLK = ~MB_CLK;

  typedef struct {
    logic [7:0]  typ;
    logic [7:0]  prod;
    logic [15:0] mfg;
    bit          sticky;
  } board_t;

  typedef struct {
    bit          is_done;
    logic [6:0]  idx;
    logic [3:0]  data;
    logic [2:0]  cnt;
    logic        err;
    logic [7:0]  typ;
    logic [7:0]  prod;
    logic [15:0] mfg;
  } exp_t;

  board_t boards[$];
  exp_t   expq[$];
  int     n_tests = 0;
  int     n_fail = 0;
  int     cyc = 0;
  int     ack_dly = 0;
  bit     pop_pending = 0;
  bit     hang_write = 0;
  logic   prev_as = 1'b1;

  always @(posedge MB_CLK) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic board_t mk(input logic [7:0] t, input logic [7:0] p, input logic [15:0] m,
                                input bit s);
    board_t b;
    b.typ = t; b.prod = p; b.mfg = m; b.sticky = s;
    return b;
  endfunction

  // Card-side view of the config nibbles: type raw, everything else inverted
  function automatic logic [3:0] nib(input board_t b, input logic [6:0] i);
    case (i)
      7'h00:   return b.typ[7:4];
      7'h01:   return b.typ[3:0];
      7'h02:   return ~b.prod[7:4];
      7'h03:   return ~b.prod[3:0];
      7'h08:   return ~b.mfg[15:12];
      7'h09:   return ~b.mfg[11:8];
      7'h0A:   return ~b.mfg[7:4];
      7'h0B:   return ~b.mfg[3:0];
      default: return 4'hF;
    endcase
  endfunction

  task automatic push_write(input logic [6:0] idx, input logic [3:0] d);
    exp_t e;
    e = '{default: 0};
    e.idx = idx; e.data = d;
    expq.push_back(e);
  endtask

  task automatic push_done(input logic [2:0] cnt, input logic err, input logic [7:0] t,
                           input logic [7:0] p, input logic [15:0] m);
    exp_t e;
    e = '{default: 0};
    e.is_done = 1; e.cnt = cnt; e.err = err; e.typ = t; e.prod = p; e.mfg = m;
    expq.push_back(e);
  endtask

  // Responder: the head board of the chain answers one cycle after /AS falls
  always @(negedge MB_CLK) begin
    if (!BUS_AS && boards.size() > 0 && BUS_ADDR[22:15] == 8'hE8 && !(hang_write && !BUS_RW)) begin
      if (ack_dly >= 1) begin
        BUS_DTACK = 1'b0;
        DATA_IN   = nib(boards[0], BUS_ADDR[6:0]);
        if (!BUS_RW && (BUS_ADDR[6:0] == 7'h24 || BUS_ADDR[6:0] == 7'h26)) pop_pending = 1;
      end else begin
        ack_dly++;
      end
    end else if (BUS_AS) begin
      BUS_DTACK = 1'b1;
      DATA_IN   = 4'h0;
      ack_dly   = 0;
      if (pop_pending) begin
        pop_pending = 0;
        if (boards.size() > 0 && !boards[0].sticky) void'(boards.pop_front());
      end
    end
  end

  // Monitor: one scoreboard pop per write cycle start and per DONE pulse
  always @(negedge MB_CLK) begin
    exp_t e;
    if (RESET) begin
      if (prev_as && !BUS_AS && !BUS_RW) begin
        $display("[TB] write idx=%02h data=%0h", BUS_ADDR[6:0], DATA_OUT);
        check("write_expected", 32'(expq.size() > 0), 32'(1));
        if (expq.size() > 0) begin
          e = expq.pop_front();
          check("write_kind", 32'(e.is_done), 32'(0));
          check("write_addr", 32'(BUS_ADDR), 32'({8'hE8, 8'h00, e.idx}));
          check("write_data", 32'(DATA_OUT), 32'(e.data));
          check("write_oe", 32'(DATA_OE), 32'(1));
        end
      end
      if (DONE) begin
        $display("[TB] done count=%0d err=%0d type=%02h prod=%02h mfg=%04h",
                 BOARD_COUNT, ERR, LAST_TYPE, LAST_PRODUCT, LAST_MFG);
        check("done_expected", 32'(expq.size() > 0), 32'(1));
        if (expq.size() > 0) begin
          e = expq.pop_front();
          check("done_kind", 32'(e.is_done), 32'(1));
          check("done_count", 32'(BOARD_COUNT), 32'(e.cnt));
          check("done_err", 32'(ERR), 32'(e.err));
          check("done_type", 32'(LAST_TYPE), 32'(e.typ));
          check("done_prod", 32'(LAST_PRODUCT), 32'(e.prod));
          check("done_mfg", 32'(LAST_MFG), 32'(e.mfg));
          check("done_busy", 32'(BUSY), 32'(0));
        end
      end
    end
    prev_as = BUS_AS;
  end

  task automatic pulse_start(input logic [7:0] base);
    @(negedge MB_CLK);
    ALLOC_BASE = base;
    START = 1'b1;
    @(negedge MB_CLK);
    START = 1'b0;
  endtask

  task automatic wait_done(input string name, output int t_done);
    int k;
    k = 0;
    while (!DONE && k < 5000) begin
      @(negedge MB_CLK);
      k++;
    end
    t_done = cyc;
    if (!DONE) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s_done_timeout: no DONE within 5000 cycles", name);
    end
    @(negedge MB_CLK);
    @(negedge MB_CLK);
    check({name, "_queue_empty"}, 32'(expq.size()), 32'(0));
    expq.delete();
  endtask

  initial begin
    #500us;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, t1, k;
    repeat (3) @(negedge MB_CLK);
    check("rst_as", 32'(BUS_AS), 32'(1));
    check("rst_uds", 32'(BUS_UDS), 32'(1));
    check("rst_lds", 32'(BUS_LDS), 32'(1));
    check("rst_rw", 32'(BUS_RW), 32'(1));
    check("rst_addr", 32'(BUS_ADDR), 32'(0));
    check("rst_oe", 32'(DATA_OE), 32'(0));
    check("rst_dout", 32'(DATA_OUT), 32'(0));
    check("rst_busy_done", 32'({BUSY, DONE, ERR}), 32'(0));
    check("rst_count", 32'(BOARD_COUNT), 32'(0));
    check("rst_last", 32'({LAST_TYPE, LAST_PRODUCT, LAST_MFG}), 32'(0));
    RESET = 1'b1;

    // One 512K board at 0x20
    boards.push_back(mk(8'hC4, 8'h12, 16'h0A55, 0));
    push_write(7'h25, 4'h0);
    push_write(7'h24, 4'h2);
    push_done(3'd1, 1'b0, 8'hC4, 8'h12, 16'h0A55);
    pulse_start(8'h20);
    wait_done("one_board", t1);

    // 8MB board does not fit below 0xA0
    boards.push_back(mk(8'hC0, 8'h34, 16'h1234, 0));
    push_write(7'h26, 4'h0);
    push_done(3'd0, 1'b1, 8'hC0, 8'h34, 16'h1234);
    pulse_start(8'h30);
    wait_done("too_big", t1);

    // 64K then 512K; a START while busy must not restart the run
    boards.push_back(mk(8'hC1, 8'h11, 16'h2222, 0));
    boards.push_back(mk(8'hC4, 8'h77, 16'h0ABC, 0));
    push_write(7'h25, 4'h1);
    push_write(7'h24, 4'h2);
    push_write(7'h25, 4'h8);
    push_write(7'h24, 4'h2);
    push_done(3'd2, 1'b0, 8'hC4, 8'h77, 16'h0ABC);
    pulse_start(8'h21);
    repeat (20) @(negedge MB_CLK);
    check("busy_mid_run", 32'(BUSY), 32'(1));
    pulse_start(8'h50);
    wait_done("two_boards", t1);

    // Empty chain: single probe, DONE 66 cycles after /AS falls; LAST_* cleared by START
    push_done(3'd0, 1'b0, 8'h00, 8'h00, 16'h0000);
    pulse_start(8'h40);
    k = 0;
    while (BUS_AS && k < 200) begin
      @(negedge MB_CLK);
      k++;
    end
    t0 = cyc;
    wait_done("no_board", t1);
    check("no_board_latency", 32'(t1 - t0), 32'(66));

    // Non-Zorro-II type code gets shut up
    boards.push_back(mk(8'h84, 8'h56, 16'hBEEF, 0));
    push_write(7'h26, 4'h0);
    push_done(3'd0, 1'b1, 8'h84, 8'h56, 16'hBEEF);
    pulse_start(8'h20);
    wait_done("bad_type", t1);

    // Board that never leaves the chain: capped at seven assignments
    boards.push_back(mk(8'hC1, 8'h9A, 16'h07DB, 1));
    for (int b = 0; b < 7; b++) begin
      push_write(7'h25, 4'(b));
      push_write(7'h24, 4'h1);
    end
    push_done(3'd7, 1'b0, 8'hC1, 8'h9A, 16'h07DB);
    pulse_start(8'h10);
    wait_done("sticky", t1);
    boards.delete();

    // Reset asserted while ASSIGN_LO waits for /DTACK
    boards.push_back(mk(8'hC4, 8'h12, 16'h0A55, 0));
    hang_write = 1;
    push_write(7'h25, 4'h0);
    pulse_start(8'h20);
    k = 0;
    while (!(!BUS_AS && !BUS_RW) && k < 500) begin
      @(negedge MB_CLK);
      k++;
    end
    repeat (5) @(negedge MB_CLK);
    check("pre_reset_as", 32'(BUS_AS), 32'(0));
    @(posedge MB_CLK);
    #2 RESET = 1'b0;
    #1;
    check("midrst_as_uds", 32'({BUS_AS, BUS_UDS}), 32'(3));
    check("midrst_oe", 32'(DATA_OE), 32'(0));
    check("midrst_rw", 32'(BUS_RW), 32'(1));
    check("midrst_busy", 32'(BUSY), 32'(0));
    check("midrst_last", 32'({BOARD_COUNT, LAST_TYPE}), 32'(0));
    check("midrst_queue_empty", 32'(expq.size()), 32'(0));
    @(negedge MB_CLK);
    hang_write = 0;
    boards.delete();
    RESET = 1'b1;
    repeat (3) @(negedge MB_CLK);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/autoconfig_host.md
Name: autoconfig_host

Overview:
- Zorro II AutoConfig initiator for 68000 bring-up and self-test; mirrors what expansion.library does.
- Runs real 68000-style bus cycles at $E8xxxx in the MB_CLK domain and reads each board's identity nibbles.
- Allocates an aligned base address in the Zorro II window and writes it to the board, or shuts the board up.
- Repeats until no board answers or MAX_BOARDS is reached. Used to enumerate our FLASH card and others without booting the OS.

Parameters:
- DTACK_TIMEOUT, 64: MB_CLK cycles to wait for /DTACK before the cycle is declared "no board".
- MAX_BOARDS, 7: enumeration cap.
- WINDOW_HI, 8'hA0: exclusive upper limit for A23:A16 of any allocation.

Ports:
- MB_CLK  in  1  7MHz bus clock; all logic on the rising edge.
- RESET  in  1  asynchronous, active-low.
- START  in  1  one-cycle pulse; begins enumeration; ignored while BUSY.
- ALLOC_BASE  in  8  first candidate A23:A16, sampled on START.
- BUS_AS  out  1  /AS.
- BUS_UDS  out  1  /UDS.
- BUS_LDS  out  1  /LDS.
- BUS_RW  out  1  1 = read.
- BUS_ADDR  out  23  A23:A1.
- DATA_OUT  out  4  D15:12 write nibble.
- DATA_OE  out  1  drives D15:12 when 1.
- DATA_IN  in  4  D15:12 read nibble.
- BUS_DTACK  in  1  /DTACK, active-low, sampled on MB_CLK.
- BUSY  out  1  enumeration in progress.
- DONE  out  1  one-cycle pulse at end of enumeration.
- BOARD_COUNT  out  3  boards assigned a base this run.
- ERR  out  1  sticky per run: at least one board was shut up.
- LAST_TYPE  out  8  er_Type of the last board read.
- LAST_PRODUCT  out  8  product code, de-inverted.
- LAST_MFG  out  16  manufacturer, de-inverted.

Behaviour:
- Reset (immediate, including mid-cycle):
  - BUS_AS = BUS_UDS = BUS_LDS = BUS_RW = 1; BUS_ADDR = 0; DATA_OE = 0; DATA_OUT = 0.
  - BUSY = 0; DONE = 0; BOARD_COUNT = 0; ERR = 0; LAST_* = 0.
  - Controller returns to IDLE.
- Bus cycle engine. Word index i is A7:A1; A23:A16 = $E8; other address bits 0.
  - ADDR: drive address, RW; DATA_OE = 1 and DATA_OUT valid for writes.
  - ASSERT: BUS_AS = 0, BUS_UDS = 0. BUS_LDS stays 1 throughout.
  - WAIT: count MB_CLK; when /DTACK is sampled low, go to LATCH. If the count reaches DTACK_TIMEOUT, abort as "no board".
  - LATCH: capture DATA_IN (reads).
  - END: negate AS/UDS; next cycle release DATA_OE. Minimum one idle cycle between bus cycles.
  - Unterminated cycles cost DTACK_TIMEOUT + 2 MB_CLK.
- Enumeration FSM: IDLE -> PROBE -> READ_ID -> DECIDE -> (ASSIGN_LO, ASSIGN_HI | SHUTUP) -> NEXT -> PROBE ... -> FINISH.
  - PROBE: read i = 0x00. Timeout -> FINISH.
  - READ_ID reads, in order:
    - i = 0x01 -> er_Type high/low nibble, raw.
    - i = 0x02, 0x03 -> product, inverted.
    - i = 0x08..0x0B -> manufacturer, inverted, MSN first.
  - Any timeout inside READ_ID -> FINISH with ERR = 1.
- DECIDE:
  - type[7:6] != 2'b11 -> SHUTUP, ERR = 1.
  - Size in 64K units, from type[2:0]: 000 = 128, 001 = 1, 010 = 2, 011 = 4, 100 = 8, 101 = 16, 110 = 32, 111 = 64.
  - Aligned base = next_base rounded up to a multiple of units, computed in 9 bits.
  - If aligned + units > WINDOW_HI (9-bit compare, no wrap) -> SHUTUP, ERR = 1. Otherwise ASSIGN.
- ASSIGN:
  - Write i = 0x25 with base[3:0] first, then i = 0x24 with base[7:4].
  - Then next_base = aligned + units and BOARD_COUNT++.
- SHUTUP: write i = 0x26 with data 0.
- Write timeouts -> FINISH with ERR = 1.
- NEXT: if BOARD_COUNT plus shut-up boards equals MAX_BOARDS -> FINISH; else PROBE.
- FINISH: BUSY = 0; DONE pulses one cycle; BOARD_COUNT, ERR and LAST_* hold until the next START.
- START clears BOARD_COUNT, ERR and LAST_*, loads next_base from ALLOC_BASE, and sets BUSY the next cycle.

Test Plan:
- Responder model: type nibbles C,4 (er_Type 0xC4, 512K); ALLOC_BASE = 0x20 -> writes 0x25 <- 0x0, then 0x24 <- 0x2; next probe times out; DONE; BOARD_COUNT = 1, ERR = 0, LAST_TYPE = 0xC4.
- 8MB board (type 0xC0) with ALLOC_BASE = 0x30 -> aligned 0x80, 0x80 + 0x80 > 0xA0 -> single write to 0x26; ERR = 1; BOARD_COUNT = 0.
- Two chained boards, 64K then 512K, ALLOC_BASE = 0x21 -> bases 0x21, then 0x28; BOARD_COUNT = 2.
- No responder -> one probe, timeout after 64 cycles; DONE 66 cycles after ASSERT; BOARD_COUNT = 0, ERR = 0.
- Type 0x84 -> shut up, ERR = 1. A board that never drops out of the chain -> stops after 7 boards.
- RESET asserted during ASSIGN_LO WAIT -> BUS_AS/UDS high and DATA_OE = 0 in the same cycle; START pulse during BUSY is ignored.
